// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, shared by four requesters.
// Also decodes the 3-bit write address into a registered one-hot write enable.
module reg_file_wr_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                En,
  input  logic [3:0]          Req,
  input  logic [11:0]         Addr,
  input  logic [4*DATA_W-1:0] Data,
  output logic [3:0]          Gnt,
  output logic [7:0]          WrEn,
  output logic [DATA_W-1:0]   WrData,
  output logic                Busy
);

  logic [1:0]        ptr_q;
  logic [3:0]        gnt_q;
  logic [7:0]        wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;

  logic [3:0]        elig;
  logic              found;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic [2:0]        addr_arr [4];
  logic [DATA_W-1:0] data_arr [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_arr[i] = Addr[3*i +: 3];
      data_arr[i] = Data[DATA_W*i +: DATA_W];
    end
  end

  // Last cycle's winner is masked so it can drop or refresh Req after seeing Gnt.
  assign elig = Req & ~gnt_q;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int j = 0; j < 4; j++) begin
      idx = ptr_q + 2'(j);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ptr_q     <= 2'd0;
      gnt_q     <= 4'b0;
      wr_en_q   <= 8'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else if (En && found) begin
      ptr_q     <= win + 2'd1;
      gnt_q     <= 4'b0001 << win;
      wr_en_q   <= 8'b0000_0001 << addr_arr[win];
      wr_data_q <= data_arr[win];
      busy_q    <= 1'b1;
    end else begin
      // WrData deliberately holds its last value when idle.
      gnt_q     <= 4'b0;
      wr_en_q   <= 8'b0;
      busy_q    <= 1'b0;
    end
  end

  assign Gnt    = gnt_q;
  assign WrEn   = wr_en_q;
  assign WrData = wr_data_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Scoreboard bench for reg_file_wr_arbiter: stimulus pushes expected writes with their cycle,
// a negedge monitor pops and compares whenever the DUT presents a write.
module tb_reg_file_wr_arbiter;

  logic        Clock;
  logic        Resetn;
  logic        En;
  logic [3:0]  Req;
  logic [11:0] Addr;
  logic [31:0] Data;
  logic [3:0]  Gnt;
  logic [7:0]  WrEn;
  logic [7:0]  WrData;
  logic        Busy;

  reg_file_wr_arbiter #(.DATA_W(8)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .En     (En),
    .Req    (Req),
    .Addr   (Addr),
    .Data   (Data),
    .Gnt    (Gnt),
    .WrEn   (WrEn),
    .WrData (WrData),
    .Busy   (Busy)
  );

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [7:0] wen;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input int delta, input logic [3:0] g, input logic [7:0] w,
                      input logic [7:0] d);
    exp_t e;
    e.cyc  = cyc + delta;
    e.gnt  = g;
    e.wen  = w;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every presented write must match the next expected write, in the expected cycle.
  always @(negedge Clock) begin
    if (Gnt != 4'b0 || WrEn != 8'b0 || Busy) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: cyc %0d gnt %b wren %b data %h busy %b",
                 cyc, Gnt, WrEn, WrData, Busy);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || Gnt !== e.gnt || WrEn !== e.wen || WrData !== e.data ||
            Busy !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_write: got cyc %0d gnt %b wren %b data %h busy %b, expected cyc %0d gnt %b wren %b data %h busy 1",
                   cyc, Gnt, WrEn, WrData, Busy, e.cyc, e.gnt, e.wen, e.data);
        end
      end
    end
  end

  initial begin
    Resetn = 1'b0;
    En     = 1'b0;
    Req    = 4'b0;
    Addr   = 12'b0;
    Data   = 32'b0;
    repeat (2) step();
    chk("reset_state", {12'b0, Gnt, WrEn, WrData, 3'b0, Busy}, 32'h0);
    Resetn = 1'b1;
    step();

    // Single request, address 5, data A5.
    En        = 1'b1;
    Req       = 4'b0001;
    Addr[2:0] = 3'd5;
    Data[7:0] = 8'hA5;
    push(1, 4'b0001, 8'b0010_0000, 8'hA5);
    step();
    Req = 4'b0;
    step();

    // Grant requester 1 to address 3, then reset asynchronously mid-write.
    Req        = 4'b0010;
    Addr[5:3]  = 3'd3;
    Data[15:8] = 8'h3C;
    step();
    chk("pre_reset_write", {12'b0, Gnt, WrEn, WrData, 3'b0, Busy},
        {12'b0, 4'b0010, 8'b0000_1000, 8'h3C, 4'b0001});
    Req = 4'b0;
    #2 Resetn = 1'b0;
    #1 chk("async_reset_clear", {12'b0, Gnt, WrEn, WrData, 3'b0, Busy}, 32'h0);
    #2 Resetn = 1'b1;
    step();

    // En=0 blocks grants; after En=1 the scan must start from requester 0.
    En          = 1'b0;
    Req         = 4'b0110;
    Addr[5:3]   = 3'd1;
    Addr[8:6]   = 3'd2;
    Data[15:8]  = 8'h11;
    Data[23:16] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_low_idle", {20'b0, Gnt, WrEn}, 32'h0);
    end
    En = 1'b1;
    push(1, 4'b0010, 8'b0000_0010, 8'h11);
    step();
    Req = 4'b0100;
    push(1, 4'b0100, 8'b0000_0100, 8'h22);
    step();
    Req = 4'b0;
    step();

    // Ptr is 3: requester 3 wins before requester 0, then wrap.
    Req          = 4'b1001;
    Addr[2:0]    = 3'd0;
    Addr[11:9]   = 3'd7;
    Data[7:0]    = 8'hA0;
    Data[31:24]  = 8'hD3;
    push(1, 4'b1000, 8'b1000_0000, 8'hD3);
    step();
    Req = 4'b0001;
    push(1, 4'b0001, 8'b0000_0001, 8'hA0);
    step();
    Req = 4'b0;
    step();

    // Lone requester held continuously: granted every other cycle.
    Req         = 4'b0100;
    Addr[8:6]   = 3'd4;
    Data[23:16] = 8'h44;
    push(1, 4'b0100, 8'b0001_0000, 8'h44);
    push(3, 4'b0100, 8'b0001_0000, 8'h44);
    push(5, 4'b0100, 8'b0001_0000, 8'h44);
    repeat (6) step();
    Req = 4'b0;
    step();

    // All four requesting from Ptr=3: rotation 3,0,1,2,... on consecutive cycles.
    Req  = 4'b1111;
    Addr = {3'd3, 3'd2, 3'd1, 3'd0};
    Data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 8; k++) begin
      int r;
      r = (3 + k) % 4;
      push(k + 1, 4'b0001 << r, 8'b0000_0001 << r, 8'h10 + 8'(r));
    end
    repeat (8) step();
    Req = 4'b0;
    step();
    chk("idle_hold_wrdata", {15'b0, WrEn, WrData, Busy}, {15'b0, 8'b0, 8'h12, 1'b0});
    step();

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_missing: %0d expected writes never seen, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
